// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } seq_state_t;

  function automatic int LEN_W(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Stream, configuration and status bundle of the serial pattern detector.
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);
  localparam int LW = LEN_W(PAT_W);

  // Handshake: in_bit is consumed on every posedge where in_valid=1 and
  // cfg_load=0; there is no ready, the detector never back-pressures.
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             cfg_err;
  seq_state_t       state;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  match, match_cnt, cnt_sat, cfg_err, state
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match, match_cnt, cnt_sat, cfg_err, state
  );

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter with a sticky saturation flag; clear wins over increment.
module seq_det_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == MAX - CNT_W'(1)) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Serial bit-pattern detector with runtime-loadable pattern/length/overlap mode.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] RST_PAT = 'h0B,
  parameter int               RST_LEN = 4
) (
  input  logic      clk,
  input  logic      rstn,
  seq_det_if.slave  bus
);
  localparam int            LW        = LEN_W(PAT_W);
  localparam logic [LW-1:0] FULL      = LW'(PAT_W);
  localparam logic [LW-1:0] RLEN      = LW'(RST_LEN);
  localparam logic [0:0]    S_FILLING = 1'b0;
  localparam logic [0:0]    S_ARMED   = 1'b1;

  logic [PAT_W-1:0] hist_q, pat_q, hist_next, mask;
  logic [LW-1:0]    fill_q, len_q, fill_inc;
  logic             ovl_q, match_q, err_q;
  logic [0:0]       state_q;
  logic             accept, cfg_ok, hit;

  assign accept    = bus.in_valid && !bus.cfg_load;
  assign cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= FULL);
  assign hist_next = {hist_q[PAT_W-2:0], bus.in_bit};
  assign fill_inc  = (fill_q == FULL) ? fill_q : fill_q + LW'(1);

  // Only the newest len bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_q));
  end

  assign hit = accept && (fill_inc >= len_q) && ((hist_next & mask) == (pat_q & mask));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PAT;
      len_q   <= RLEN;
      ovl_q   <= 1'b1;
      state_q <= S_FILLING;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      match_q <= hit;
      err_q   <= bus.cfg_load && !cfg_ok;
      if (bus.cfg_load) begin
        if (cfg_ok) begin
          pat_q   <= bus.cfg_pattern;
          len_q   <= bus.cfg_len;
          ovl_q   <= bus.cfg_overlap;
          hist_q  <= '0;
          fill_q  <= '0;
          state_q <= S_FILLING;
        end
      end else if (accept) begin
        hist_q <= hist_next;
        if (hit && !ovl_q) begin
          fill_q  <= '0;
          state_q <= S_FILLING;
        end else begin
          fill_q  <= fill_inc;
          state_q <= (fill_inc >= len_q) ? S_ARMED : S_FILLING;
        end
      end
    end
  end

  // The counter advances on the accepting edge, so it is already updated
  // in the cycle the match pulse is visible.
  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.cnt_clr),
    .inc  (hit),
    .cnt  (bus.match_cnt),
    .sat  (bus.cnt_sat)
  );

  assign bus.match   = match_q;
  assign bus.cfg_err = err_q;
  assign bus.state   = seq_state_t'(state_q);

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios plus random traffic against a bit-queue model.
module tb_seq_det_param;
  import seq_det_pkg::*;

  localparam int PAT_W = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  seq_det_if #(.PAT_W(PAT_W), .CNT_W(16)) ifa ();
  seq_det_if #(.PAT_W(PAT_W), .CNT_W(2))  ifb ();

  assign ifa.in_valid = in_valid;    assign ifb.in_valid = in_valid;
  assign ifa.in_bit = in_bit;        assign ifb.in_bit = in_bit;
  assign ifa.cfg_load = cfg_load;    assign ifb.cfg_load = cfg_load;
  assign ifa.cfg_pattern = cfg_pattern; assign ifb.cfg_pattern = cfg_pattern;
  assign ifa.cfg_len = cfg_len;      assign ifb.cfg_len = cfg_len;
  assign ifa.cfg_overlap = cfg_overlap; assign ifb.cfg_overlap = cfg_overlap;
  assign ifa.cnt_clr = cnt_clr;      assign ifb.cnt_clr = cnt_clr;

  seq_det_param #(.PAT_W(PAT_W), .CNT_W(16), .RST_PAT(8'h0B), .RST_LEN(4)) dut_a (
    .clk (clk), .rstn (rstn), .bus (ifa.slave)
  );
  seq_det_param #(.PAT_W(PAT_W), .CNT_W(2), .RST_PAT(8'h0B), .RST_LEN(4)) dut_b (
    .clk (clk), .rstn (rstn), .bus (ifb.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- model + scoreboard ----------------
  int         n_chk = 0;
  int         n_err = 0;
  bit         hist_q[$];        // accepted bits since last clear, oldest first
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         cnt_a, cnt_b;
  bit         sat_a, sat_b;
  logic [1:0] exp_q[$];         // {cfg_err, match} per cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit tail_matches();
    if (hist_q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (hist_q[hist_q.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit m = 1'b0;
    bit e = 1'b0;
    if (!rstn) begin
      hist_q.delete();
      m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
      cnt_a = 0; cnt_b = 0; sat_a = 1'b0; sat_b = 1'b0;
    end else begin
      if (cfg_load) begin
        if (cfg_len >= 1 && cfg_len <= PAT_W) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          hist_q.delete();
        end else begin
          e = 1'b1;
        end
      end else if (in_valid) begin
        hist_q.push_back(in_bit);
        if (hist_q.size() > PAT_W) void'(hist_q.pop_front());
        m = tail_matches();
        if (m && !m_ovl) hist_q.delete();
      end
      if (cnt_clr) begin
        cnt_a = 0; cnt_b = 0; sat_a = 1'b0; sat_b = 1'b0;
      end else if (m) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_a == 65535) sat_a = 1'b1;
        if (cnt_b < 3) cnt_b++;
        if (cnt_b == 3) sat_b = 1'b1;
      end
    end
    exp_q.push_back({e, m});
  endtask

  // One clock: model consumes the inputs of this edge, outputs checked 1 time unit later.
  task automatic cycle();
    logic [1:0] ex;
    @(posedge clk);
    model_step();
    #1;
    ex = exp_q.pop_front();
    check("match_a",   32'(ifa.match),     32'(ex[0]));
    check("match_b",   32'(ifb.match),     32'(ex[0]));
    check("cfg_err_a", 32'(ifa.cfg_err),   32'(ex[1]));
    check("cnt_a",     32'(ifa.match_cnt), 32'(cnt_a));
    check("sat_a",     32'(ifa.cnt_sat),   32'(sat_a));
    check("cnt_b",     32'(ifb.match_cnt), 32'(cnt_b));
    check("sat_b",     32'(ifb.cnt_sat),   32'(sat_b));
    check("state_a",   32'(ifa.state),     (hist_q.size() >= m_len) ? 32'(ARMED) : 32'(FILLING));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
  endtask

  task automatic clear_cnt();
    idle_inputs();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                          input bit v = 1'b0, input bit b = 1'b0);
    idle_inputs();
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = v; in_bit = b;
    cycle();
    idle_inputs();
  endtask

  // Sends a bit string, optionally with idle gaps, and counts observed match pulses.
  task automatic send_str(input string s, input bit gaps, output int n_match);
    n_match = 0;
    for (int i = 0; i < s.len(); i++) begin
      idle_inputs();
      in_valid = 1'b1;
      in_bit   = (s[i] == "1");
      cycle();
      n_match += int'(ifa.match);
      if (gaps) begin
        idle_inputs();
        repeat ($urandom_range(1, 3)) begin
          cycle();
          n_match += int'(ifa.match);
        end
      end
    end
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nm;
    int r;
    idle_inputs();
    rstn = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;

    // 1: reset defaults, overlapping 1011
    do_reset();
    check("rst_cnt",   32'(ifa.match_cnt), 32'd0);
    check("rst_state", 32'(ifa.state),     32'(FILLING));
    send_str("1011011", 1'b0, nm);
    check("t1_matches", 32'(nm), 32'd2);
    check("t1_cnt",     32'(ifa.match_cnt), 32'd2);

    // 2: non-overlapping 1011
    clear_cnt();
    load_cfg(8'h0B, 4'd4, 1'b0);
    send_str("1011011", 1'b0, nm);
    check("t2a_matches", 32'(nm), 32'd1);
    load_cfg(8'h0B, 4'd4, 1'b0);
    send_str("10111011", 1'b0, nm);
    check("t2b_matches", 32'(nm), 32'd2);

    // 3: 8-bit pattern with valid gaps, then a rejected length
    load_cfg(8'hF0, 4'd8, 1'b1);
    send_str("11110000", 1'b1, nm);
    check("t3_matches", 32'(nm), 32'd1);
    load_cfg(8'h55, 4'd9, 1'b0);
    check("t3_cfg_err", 32'(ifa.cfg_err), 32'd1);
    send_str("11110000", 1'b0, nm);
    check("t3_kept_cfg", 32'(nm), 32'd1);

    // 4: single-bit pattern saturates the 2-bit counter; clear beats a coincident match
    clear_cnt();
    load_cfg(8'h01, 4'd1, 1'b1);
    send_str("11111", 1'b0, nm);
    check("t4_matches", 32'(nm), 32'd5);
    check("t4_cnt_b",   32'(ifb.match_cnt), 32'd3);
    check("t4_sat_b",   32'(ifb.cnt_sat),   32'd1);
    idle_inputs();
    in_valid = 1'b1; in_bit = 1'b1; cnt_clr = 1'b1;
    cycle();
    check("t4_clr_match", 32'(ifb.match),     32'd1);
    check("t4_clr_cnt",   32'(ifb.match_cnt), 32'd0);
    idle_inputs();

    // 5: reset mid-pattern discards history
    do_reset();
    send_str("101", 1'b0, nm);
    do_reset();
    send_str("1", 1'b0, nm);
    check("t5_no_match", 32'(nm), 32'd0);
    send_str("1011", 1'b0, nm);
    check("t5_match", 32'(nm), 32'd1);

    // 6: load with a coincident valid bit drops that bit
    load_cfg(8'h0B, 4'd4, 1'b1, 1'b1, 1'b1);
    send_str("011", 1'b0, nm);
    check("t6_dropped", 32'(nm), 32'd0);
    send_str("1011", 1'b0, nm);
    check("t6_match", 32'(nm), 32'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rstn = 1'b0;
      end else if (r < 7) begin
        cfg_load    = 1'b1;
        cfg_pattern = 8'($urandom);
        cfg_len     = 4'($urandom_range(0, 9));
        cfg_overlap = 1'($urandom);
        in_valid    = 1'($urandom);
        in_bit      = 1'($urandom);
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bit   = 1'($urandom);
        cnt_clr  = (r < 9);
      end
      cycle();
      rstn = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
